conv_tap_sequencer: RTL and testbench
=====================================

Name: conv_tap_sequencer

Overview:
- Control FSM for one 1-D convolution layer.
- Issues tap-coefficient addresses to the registered-output filter ROM and matching sample addresses to the input memory.
- Generates aligned clear/accumulate strobes for the downstream MAC and presents each finished output under a valid/ready handshake.
- Sits between the layer start logic and the fmem ROM / xmem / MAC datapath.

Parameters:
- N, 30, number of input samples.
- M, 9, number of filter taps. Requires M >= 2 and N >= M.
- XA_W, $clog2(N), xmem address width (localparam, derived).
- FA_W, $clog2(M), fmem address width (localparam, derived).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a layer; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final output handshake.
- addr_x  out  XA_W  xmem read address, value j+k.
- addr_f  out  FA_W  fmem ROM read address, value k.
- mac_en  out  1  accumulate strobe; product data valid this cycle.
- mac_clr  out  1  with mac_en: load the product instead of adding it.
- y_valid  out  1  MAC result for output y_idx is final.
- y_ready  in  1  consumer accepts the output.
- y_idx  out  XA_W  index j of the current output, 0..N-M.
- stall_cnt  out  16  back-pressure cycle count; see Optional Feature.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. busy, done, mac_en, mac_clr, y_valid = 0. addr_x, addr_f, y_idx, j, k = 0.
- States: IDLE, RUN, FLUSH, OUT, FIN.
- IDLE:
  - start=1 -> RUN with j=0, k=0.
  - Any other input is ignored.
- RUN:
  - Drive addr_f=k, addr_x=j+k.
  - k increments each cycle.
  - When k==M-1 -> FLUSH and k clears.
- Read latency: fmem ROM and xmem are 1-cycle registered reads. mac_en is therefore a registered copy of (state==RUN), delayed one cycle.
- mac_clr is high only on the mac_en cycle that corresponds to k==0.
- FLUSH:
  - One cycle; mac_en is high for tap M-1.
  - Addresses hold their last values.
  - -> OUT.
- OUT:
  - y_valid=1, y_idx=j. Both are held stable until y_ready.
  - No mac_en in this state.
  - On y_valid&&y_ready:
    - If j==N-M -> FIN.
    - Else j increments -> RUN.
- FIN:
  - done=1 for this one cycle, busy=1.
  - -> IDLE.
- Timing with y_ready held high:
  - Each output takes M+2 cycles: RUN M, FLUSH 1, OUT 1.
  - Total layer time is (N-M+1)(M+2)+1 cycles from the first RUN cycle to done.
- Boundaries:
  - start while busy is ignored; no restart.
  - y_ready low in OUT: stall indefinitely with all outputs frozen.
  - y_ready high outside OUT has no effect.
  - addr_x never exceeds N-1. addr_f never exceeds M-1.
- reset_n asserted mid-layer: immediate return to reset values. No done pulse. The partial MAC result is discarded by the consumer because y_valid drops.

Optional Feature:
- Macro: CONV_TAP_SEQUENCER_STALL_CNT_EN.
- Defined:
  - stall_cnt counts cycles with y_valid=1 and y_ready=0.
  - Cleared to 0 on an accepted start.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE.
  - Reset value 0.
- Undefined: stall_cnt is tied to 0 and no counter logic is inferred.

Test Plan:
- Reset then idle: start=0 for 20 cycles -> busy=0, mac_en=0, y_valid=0, all addresses 0.
- Single layer, N=30, M=9, y_ready=1: start at cycle 0. Required response:
  - addr_f sequence 0..8, repeated 22 times.
  - addr_x for j=21 runs 21..29.
  - 22 y_valid handshakes with y_idx 0..21.
  - done exactly once, at cycle 243.
- Alignment: check mac_en follows the RUN cycles by exactly one cycle, and that mac_clr coincides only with the mac_en for k=0 (9 mac_en per output).
- Back-pressure: hold y_ready=0 for 5 cycles at j=3 -> y_valid and y_idx=3 stable, no mac_en during the stall, done delayed by 5 cycles. With the macro defined, stall_cnt=5.
- start during busy: pulse start at j=10 -> no change in sequence, j continues to 11.
- Async reset mid-RUN at j=7, k=4: all outputs go to 0 immediately, without waiting for a clk edge. A new start after release begins at j=0, k=0.

Source files
------------

// File: rtl/conv_tap_sequencer.sv
// Tap/sample address sequencer and MAC strobe generator for one 1-D convolution layer.
// Optional back-pressure counter enabled by CONV_TAP_SEQUENCER_STALL_CNT_EN.
module conv_tap_sequencer #(
    parameter int N = 30,
    parameter int M = 9,
    localparam int XA_W = $clog2(N),
    localparam int FA_W = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [XA_W-1:0] addr_x,
    output logic [FA_W-1:0] addr_f,
    output logic            mac_en,
    output logic            mac_clr,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [XA_W-1:0] y_idx,
    output logic [15:0]     stall_cnt
);

    localparam logic [FA_W-1:0] K_LAST = FA_W'(M - 1);
    localparam logic [XA_W-1:0] J_LAST = XA_W'(N - M);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, OUT, FIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [FA_W-1:0] k;
    logic [XA_W-1:0] j;
    logic [FA_W-1:0] af_hold;
    logic [XA_W-1:0] ax_hold;
    logic [XA_W-1:0] tap_addr;
    logic            mac_en_p1;
    logic            mac_clr_p1;

    assign tap_addr = j + XA_W'(k);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = OUT;
            OUT:     if (y_ready) state_nxt = (j == J_LAST) ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: ROM/xmem reads are registered, so strobes lag the RUN cycle by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k          <= '0;
            j          <= '0;
            af_hold    <= '0;
            ax_hold    <= '0;
            mac_en_p1  <= 1'b0;
            mac_clr_p1 <= 1'b0;
        end else begin
            mac_en_p1  <= (state == RUN);
            mac_clr_p1 <= (state == RUN) && (k == '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        k <= '0;
                        j <= '0;
                    end
                end
                RUN: begin
                    af_hold <= k;
                    ax_hold <= tap_addr;
                    k       <= (k == K_LAST) ? '0 : k + FA_W'(1);
                end
                OUT: begin
                    if (y_ready && (j != J_LAST)) j <= j + XA_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outside RUN the addresses hold the last issued tap so the ROM output stays put.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == FIN);
        y_valid = (state == OUT);
        addr_f  = (state == RUN) ? k : af_hold;
        addr_x  = (state == RUN) ? tap_addr : ax_hold;
    end

    assign mac_en  = mac_en_p1;
    assign mac_clr = mac_clr_p1;
    assign y_idx   = j;

`ifdef CONV_TAP_SEQUENCER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_q <= '0;
        end else if ((state == OUT) && !y_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Directed bench for conv_tap_sequencer: cycle-exact output vectors per layer scenario.
module tb_conv_tap_sequencer;

    localparam int N    = 30;
    localparam int M    = 9;
    localparam int XA_W = 5;
    localparam int FA_W = 4;
    localparam int NOUT = N - M + 1;
    localparam int PER  = M + 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [XA_W-1:0] addr_x;
    logic [FA_W-1:0] addr_f;
    logic            mac_en;
    logic            mac_clr;
    logic            y_valid;
    logic            y_ready;
    logic [XA_W-1:0] y_idx;
    logic [15:0]     stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [FA_W-1:0] idle_af;
    logic [XA_W-1:0] idle_ax;
    logic [XA_W-1:0] idle_yi;

    always #5 clk = ~clk;

    conv_tap_sequencer #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .addr_x    (addr_x),
        .addr_f    (addr_f),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_idx     (y_idx),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [18:0] obs_vec();
        return {busy, done, mac_en, mac_clr, y_valid, addr_f, addr_x, y_idx};
    endfunction

    task automatic test_reset();
        logic [18:0] obs;
        reset_n = 1'b0;
        start   = 1'b0;
        y_ready = 1'b0;
        #2;
        obs = obs_vec();
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h want=%h", obs, 19'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            obs = obs_vec();
            n_checks++;
            if (obs !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs, 19'd0);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
        end
        idle_af = '0;
        idle_ax = '0;
        idle_yi = '0;
    endtask

    // Full layer with y_ready high except for stall_len cycles at output stall_j;
    // busy_c >= 0 pulses start again at that cycle while the layer is running.
    task automatic test_layer(input string name, input int stall_len, input int stall_j,
                              input int busy_c);
        int done_c;
        int pre;
        int n_done;
        int n_hs;
        int n_en;
        int n_clr;
        done_c = NOUT * PER + 1 + stall_len;
        pre    = 1 + stall_j * PER + M + 1;
        n_done = 0;
        n_hs   = 0;
        n_en   = 0;
        n_clr  = 0;
        @(posedge clk); #1;
        for (int c = 0; c <= done_c + 1; c++) begin
            logic [18:0]     obs;
            logic [18:0]     exp;
            logic            b_e, d_e, en_e, clr_e, yv_e;
            logic [FA_W-1:0] af_e;
            logic [XA_W-1:0] ax_e;
            logic [XA_W-1:0] yi_e;
            int              t;
            int              o;
            int              ph;
            start   = (c == 0) || (c == busy_c);
            y_ready = !((stall_len > 0) && (c >= pre) && (c < pre + stall_len));
            b_e = 1'b1; d_e = 1'b0; en_e = 1'b0; clr_e = 1'b0; yv_e = 1'b0;
            af_e = '0; ax_e = '0; yi_e = '0;
            if (c == 0) begin
                b_e = 1'b0; af_e = idle_af; ax_e = idle_ax; yi_e = idle_yi;
            end else if (c == done_c + 1) begin
                b_e = 1'b0; af_e = FA_W'(M - 1); ax_e = XA_W'(N - 1); yi_e = XA_W'(NOUT - 1);
            end else if (c == done_c) begin
                d_e = 1'b1; af_e = FA_W'(M - 1); ax_e = XA_W'(N - 1); yi_e = XA_W'(NOUT - 1);
            end else begin
                t = c - 1;
                if ((stall_len > 0) && (c >= pre)) t = (c < pre + stall_len) ? pre - 1 : c - 1 - stall_len;
                o  = t / PER;
                ph = t % PER;
                yi_e = XA_W'(o);
                if (ph < M) begin
                    en_e = (ph >= 1); clr_e = (ph == 1);
                    af_e = FA_W'(ph); ax_e = XA_W'(o + ph);
                end else begin
                    en_e = (ph == M); yv_e = (ph == M + 1);
                    af_e = FA_W'(M - 1); ax_e = XA_W'(o + M - 1);
                end
            end
            exp = {b_e, d_e, en_e, clr_e, yv_e, af_e, ax_e, yi_e};
            @(negedge clk);
            obs = obs_vec();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s c=%0d got=%h want=%h", name, c, obs, exp);
            end
            if (done === 1'b1) n_done++;
            if ((y_valid === 1'b1) && y_ready) n_hs++;
            if (mac_en === 1'b1) n_en++;
            if (mac_clr === 1'b1) n_clr++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 1) begin n_fail++; $display("FAIL %s_done_count got=%0d want=1", name, n_done); end
        n_checks++;
        if (n_hs != NOUT) begin n_fail++; $display("FAIL %s_handshakes got=%0d want=%0d", name, n_hs, NOUT); end
        n_checks++;
        if (n_en != NOUT * M) begin n_fail++; $display("FAIL %s_mac_en_count got=%0d want=%0d", name, n_en, NOUT * M); end
        n_checks++;
        if (n_clr != NOUT) begin n_fail++; $display("FAIL %s_mac_clr_count got=%0d want=%0d", name, n_clr, NOUT); end
        idle_af = FA_W'(M - 1);
        idle_ax = XA_W'(N - 1);
        idle_yi = XA_W'(NOUT - 1);
    endtask

    task automatic test_single_layer();
        test_layer("layer", 0, 0, -1);
    endtask

    task automatic test_back_pressure();
        logic [15:0] want;
        test_layer("backpressure", 5, 3, -1);
`ifdef CONV_TAP_SEQUENCER_STALL_CNT_EN
        want = 16'd5;
`else
        want = 16'd0;
`endif
        n_checks++;
        if (stall_cnt !== want) begin
            n_fail++;
            $display("FAIL bp_stall_cnt got=%0d want=%0d", stall_cnt, want);
        end
    endtask

    task automatic test_start_busy();
        test_layer("start_busy", 0, 0, 1 + 10 * PER + 3);
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL start_busy_stall_cnt got=%0d want=0", stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] obs;
        logic [18:0] want;
        @(posedge clk); #1;
        for (int c = 0; c <= 82; c++) begin
            start   = (c == 0);
            y_ready = 1'b1;
            if (c < 82) begin
                @(posedge clk); #1;
            end
        end
        #1;
        // Cycle 82 is output j=7, tap k=4.
        want = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FA_W'(4), XA_W'(11), XA_W'(7)};
        obs  = obs_vec();
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL async_pre got=%h want=%h", obs, want);
        end
        reset_n = 1'b0;
        #1;
        obs = obs_vec();
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL async_immediate got=%h want=%h", obs, 19'd0);
        end
        @(negedge clk);
        obs = obs_vec();
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL async_held got=%h want=%h", obs, 19'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_af = '0;
        idle_ax = '0;
        idle_yi = '0;
        test_layer("after_reset", 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_back_pressure();
        test_start_busy();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
